ddr_rd_arb: RTL and testbench
=============================

Name: ddr_rd_arb

Overview:
Read-channel arbiter/sequencer for one DDR port, shared by up to REQ_NUM buffer loaders (ibuf, dbuf, pbuf, abuf).
- Accepts per-requester transfer descriptors.
- Grants one requester at a time, round-robin.
- Starts the single downstream ddr_addr_gen with the granted descriptor.
- Routes the returning read data stream's valid/ready to the granted client only.
- Releases the grant once every data beat of the transfer has been consumed.
- Replaces hand-driven ready muxes and per-buffer sel signals.

Parameters:
- REQ_NUM, 4, number of requesters.
- DDR_ADDR_W, 32, DDR address width.
- BURST_W, 8, burst length / burst count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  REQ_NUM  descriptor valid per requester
- req_ready  out  REQ_NUM  descriptor accepted (one-hot, one cycle)
- req_st_addr  in  REQ_NUM*DDR_ADDR_W  start address per requester
- req_burst  in  REQ_NUM*BURST_W  beats per burst per requester
- req_step  in  REQ_NUM*DDR_ADDR_W  address stride between bursts
- req_burst_num  in  REQ_NUM*BURST_W  number of bursts
- req_done  out  REQ_NUM  one-cycle pulse when the granted transfer fully completes
- gen_start  out  1  one-cycle start pulse to ddr_addr_gen
- gen_st_addr  out  DDR_ADDR_W  registered descriptor field
- gen_burst  out  BURST_W  registered descriptor field
- gen_step  out  DDR_ADDR_W  registered descriptor field
- gen_burst_num  out  BURST_W  registered descriptor field
- gen_done  in  1  address generator finished issuing addresses
- ddr_valid  in  1  read data beat valid
- ddr_ready  out  1  = cli_ready[grant] while in XFER, else 0
- cli_valid  out  REQ_NUM  = ddr_valid on the granted bit only, while in XFER
- cli_ready  in  REQ_NUM  client ready
- grant  out  REQ_NUM  one-hot current owner, 0 when idle
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, addr_done=0.
  - All outputs 0, including gen_* fields, req_ready and req_done.
  - Reset in any state aborts immediately; no req_done is emitted.
  - Downstream gen and clients must also be reset.
- States: IDLE → ISSUE → XFER → DONE → IDLE.
- IDLE:
  - If any req_valid, pick the first set bit at or after rr_ptr, wrapping modulo REQ_NUM.
  - Assert req_ready for that bit for exactly this cycle.
  - Latch its descriptor into gen_* and set grant.
  - Compute total = burst*burst_num, 2*BURST_W bits, unsigned, no overflow.
  - If total==0, go to DONE and never pulse gen_start; otherwise go to ISSUE.
  - Arbitration-to-ISSUE latency is 1 cycle.
- ISSUE: gen_start=1 for one cycle; beat_cnt=0; addr_done=0; go to XFER.
- XFER:
  - A beat is consumed when ddr_valid && ddr_ready; increment beat_cnt on each consumed beat.
  - gen_done sets the sticky flag addr_done.
  - Exit to DONE when addr_done is set (or gen_done in the same cycle) AND the beat_cnt after the increment equals total.
  - Beats may arrive before gen_done, and gen_done may come before the last beat; both orders are legal.
- DONE:
  - req_done[grant]=1 for one cycle.
  - rr_ptr = granted index + 1 (mod REQ_NUM).
  - grant=0; go to IDLE.
  - Next arbitration is possible the following cycle, so a request-to-request turnaround costs 1 idle cycle.
- ddr_valid outside XFER is not acknowledged: ddr_ready=0.
- Beats beyond total cannot occur, because the exit happens on the last beat.
- Descriptor inputs are sampled only in the accept cycle. Requesters hold req_valid and the fields stable until req_ready.
- req_valid deasserted before grant is legal; that requester is simply skipped.
- Simultaneous requests: exactly one is granted. The others wait with req_ready=0 and no starvation: each waits at most REQ_NUM-1 transfers.

Optional Feature:
- Macro: DDR_RD_ARB_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is unused and held at 0. Intended for the configuration where the idx buffer must preload first.
- Undefined: round-robin as above.

Test Plan:
- Single request: req_valid[2]=1, st_addr=0x1000, burst=16, step=0x400, burst_num=4.
  - req_ready[2] pulses 1 cycle.
  - gen_start pulses 1 cycle later with the same fields.
  - After 64 accepted beats plus gen_done, req_done[2] pulses; grant returns to 0.
- Round-robin: all four req_valid held, each with burst=1, burst_num=1.
  - Grant order 0,1,2,3,0.
  - Each grant yields req_done 1 cycle after its single beat (given gen_done).
  - With DDR_RD_ARB_PRIO_EN, the order is 0,0,0…
- Backpressure: granted client cli_ready toggles 1/0 every cycle with ddr_valid held 1.
  - ddr_ready mirrors cli_ready; beat_cnt advances only on handshakes.
  - Non-granted cli_valid stays 0.
- Ordering of gen_done versus last beat:
  - Case 1: gen_done after the last beat.
  - Case 2: gen_done 10 cycles before the last beat.
  - Case 3: both in the same cycle.
  - In every case req_done occurs only when both conditions hold, exactly once.
- Zero-length transfers: burst_num=0, then separately burst=0.
  - No gen_start.
  - req_done 1 cycle after req_ready.
- Reset mid-XFER after 5 of 32 beats: outputs go to 0 next cycle, no req_done, rr_ptr=0; a fresh request then completes normally.

Source files
------------

// File: rtl/ddr_rd_arb.sv
// ddr_rd_arb: DDR read-channel arbiter, round-robin by default or fixed lowest-index priority when DDR_RD_ARB_PRIO_EN is defined
module ddr_rd_arb #(
  parameter int REQ_NUM    = 4,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_NUM-1:0]              req_valid,
  output logic [REQ_NUM-1:0]              req_ready,
  input  logic [REQ_NUM*DDR_ADDR_W-1:0]   req_st_addr,
  input  logic [REQ_NUM*BURST_W-1:0]      req_burst,
  input  logic [REQ_NUM*DDR_ADDR_W-1:0]   req_step,
  input  logic [REQ_NUM*BURST_W-1:0]      req_burst_num,
  output logic [REQ_NUM-1:0]              req_done,
  output logic                            gen_start,
  output logic [DDR_ADDR_W-1:0]           gen_st_addr,
  output logic [BURST_W-1:0]              gen_burst,
  output logic [DDR_ADDR_W-1:0]           gen_step,
  output logic [BURST_W-1:0]              gen_burst_num,
  input  logic                            gen_done,
  input  logic                            ddr_valid,
  output logic                            ddr_ready,
  output logic [REQ_NUM-1:0]              cli_valid,
  input  logic [REQ_NUM-1:0]              cli_ready,
  output logic [REQ_NUM-1:0]              grant,
  output logic                            busy
);
  localparam int IW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
  localparam int CW = 2 * BURST_W;
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, sel, j;
  logic [CW-1:0] beat_cnt, cnt_nx, total, total_nx;
  logic addr_done, any_req, fire, last;
  logic [DDR_ADDR_W-1:0] addr_a [REQ_NUM];
  logic [DDR_ADDR_W-1:0] step_a [REQ_NUM];
  logic [BURST_W-1:0] burst_a [REQ_NUM];
  logic [BURST_W-1:0] bnum_a [REQ_NUM];
  for (genvar r = 0; r < REQ_NUM; r++) begin : g_unpack
    assign addr_a[r]  = req_st_addr[r*DDR_ADDR_W +: DDR_ADDR_W];
    assign step_a[r]  = req_step[r*DDR_ADDR_W +: DDR_ADDR_W];
    assign burst_a[r] = req_burst[r*BURST_W +: BURST_W];
    assign bnum_a[r]  = req_burst_num[r*BURST_W +: BURST_W];
  end
  assign any_req = |req_valid;
  always_comb begin
    sel = '0;
    j = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      j = IW'((int'(rr_ptr) + i) % REQ_NUM);
      if (req_valid[j]) sel = j;
    end
  end
  assign total_nx  = CW'(burst_a[sel]) * CW'(bnum_a[sel]);
  assign req_ready = (state == IDLE && any_req && !rst) ? REQ_NUM'(1) << sel : '0;
  assign ddr_ready = (state == XFER) && |(cli_ready & grant);
  assign cli_valid = (state == XFER && ddr_valid) ? grant : '0;
  assign req_done  = (state == DONE) ? grant : '0;
  assign gen_start = state == ISSUE;
  assign busy      = state != IDLE;
  assign fire      = ddr_valid && ddr_ready;
  assign cnt_nx    = beat_cnt + CW'(fire);
  assign last      = (addr_done || gen_done) && cnt_nx == total;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? (total_nx == '0 ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nx = XFER;
      XFER:    state_nx = last ? DONE : XFER;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      addr_done     <= 1'b0;
      total         <= '0;
      gen_st_addr   <= '0;
      gen_burst     <= '0;
      gen_step      <= '0;
      gen_burst_num <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant         <= REQ_NUM'(1) << sel;
        total         <= total_nx;
        gen_st_addr   <= addr_a[sel];
        gen_burst     <= burst_a[sel];
        gen_step      <= step_a[sel];
        gen_burst_num <= bnum_a[sel];
`ifndef DDR_RD_ARB_PRIO_EN
        rr_ptr        <= (sel == IW'(REQ_NUM - 1)) ? '0 : sel + 1'b1;
`endif
      end
      if (state == ISSUE) begin
        beat_cnt  <= '0;
        addr_done <= 1'b0;
      end
      if (state == XFER) begin
        beat_cnt  <= cnt_nx;
        addr_done <= addr_done | gen_done;
      end
      if (state == DONE) grant <= '0;
    end
  end
endmodule

// File: tb/tb_ddr_rd_arb.sv
// tb_ddr_rd_arb: scoreboard-driven bench for ddr_rd_arb
module tb_ddr_rd_arb;
  localparam int N = 4, AW = 32, BW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, req_done, cli_valid, cli_ready, grant;
  logic [N*AW-1:0] req_st_addr, req_step;
  logic [N*BW-1:0] req_burst, req_burst_num;
  logic gen_start, gen_done, ddr_valid, ddr_ready, busy;
  logic [AW-1:0] gen_st_addr, gen_step;
  logic [BW-1:0] gen_burst, gen_burst_num;
  typedef struct {int idx; logic [31:0] a; logic [7:0] b; logic [31:0] s; logic [7:0] n;} desc_t;
  desc_t gen_q[$];
  int done_q[$];
  int nchk = 0, nfail = 0;
  ddr_rd_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_st_addr(req_st_addr), .req_burst(req_burst), .req_step(req_step),
    .req_burst_num(req_burst_num), .req_done(req_done), .gen_start(gen_start),
    .gen_st_addr(gen_st_addr), .gen_burst(gen_burst), .gen_step(gen_step),
    .gen_burst_num(gen_burst_num), .gen_done(gen_done), .ddr_valid(ddr_valid),
    .ddr_ready(ddr_ready), .cli_valid(cli_valid), .cli_ready(cli_ready),
    .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    if (gen_start === 1'b1) begin
      nchk++;
      if (gen_q.size() == 0) begin
        nfail++;
        $display("FAIL gen_start_unexpected got=1 exp=0");
      end else begin
        desc_t e;
        e = gen_q.pop_front();
        if ({gen_st_addr, gen_burst, gen_step, gen_burst_num, grant} !== {e.a, e.b, e.s, e.n, 4'(1 << e.idx)}) begin
          nfail++;
          $display("FAIL gen_fields got=%h/%0d/%h/%0d/%b exp=%h/%0d/%h/%0d/%b", gen_st_addr, gen_burst, gen_step,
                   gen_burst_num, grant, e.a, e.b, e.s, e.n, 4'(1 << e.idx));
        end
      end
    end
    if (req_done !== '0) begin
      nchk++;
      if (done_q.size() == 0) begin
        nfail++;
        $display("FAIL req_done_unexpected got=%b exp=0000", req_done);
      end else begin
        int d;
        d = done_q.pop_front();
        if (req_done !== 4'(1 << d)) begin
          nfail++;
          $display("FAIL req_done_owner got=%b exp=%b", req_done, 4'(1 << d));
        end
      end
    end
  end
  task automatic run(input int idx, input logic [3:0] extra, input logic [31:0] a, input logic [7:0] b,
                     input logic [31:0] s, input logic [7:0] n, input int bdel, input int gdc, input bit bp);
    int tot, beats;
    bit gd, fin;
    logic [3:0] oh;
    oh = 4'(1 << idx);
    tot = int'(b) * int'(n);
    if (tot != 0) gen_q.push_back('{idx, a, b, s, n});
    done_q.push_back(idx);
    @(negedge clk);
    req_st_addr[idx*AW +: AW] = a;
    req_burst[idx*BW +: BW] = b;
    req_step[idx*AW +: AW] = s;
    req_burst_num[idx*BW +: BW] = n;
    req_valid = oh | extra;
    #1;
    nchk++;
    if (req_ready !== oh) begin nfail++; $display("FAIL req_ready got=%b exp=%b", req_ready, oh); end
    @(negedge clk);
    req_valid = '0;
    #1;
    nchk++;
    if (req_ready !== '0) begin nfail++; $display("FAIL req_ready_pulse got=%b exp=0000", req_ready); end
    if (tot == 0) begin
      nchk++;
      if (req_done !== oh || gen_start !== 1'b0) begin
        nfail++;
        $display("FAIL zero_len got done=%b start=%b exp done=%b start=0", req_done, gen_start, oh);
      end
    end else begin
      beats = 0;
      gd = 0;
      fin = 0;
      for (int c = 1; !fin && c < 400; c++) begin
        @(negedge clk);
        ddr_valid = (c >= bdel) && beats < tot;
        cli_ready = (!bp || c % 2 == 1) ? '1 : '0;
        gen_done = (c == gdc);
        #1;
        nchk++;
        if (ddr_ready !== cli_ready[idx] || cli_valid !== (ddr_valid ? oh : 4'b0) || req_done !== '0) begin
          nfail++;
          $display("FAIL xfer_c%0d got rdy=%b cv=%b done=%b exp rdy=%b cv=%b done=0000", c, ddr_ready, cli_valid,
                   req_done, cli_ready[idx], ddr_valid ? oh : 4'b0);
        end
        if (ddr_valid && cli_ready[idx]) beats++;
        gd |= gen_done;
        fin = gd && beats == tot;
      end
      @(negedge clk);
      ddr_valid = 0;
      gen_done = 0;
      cli_ready = '0;
      #1;
      nchk++;
      if (!fin || req_done !== oh || grant !== oh) begin
        nfail++;
        $display("FAIL xfer_done got fin=%b done=%b grant=%b exp fin=1 done=%b grant=%b", fin, req_done, grant, oh, oh);
      end
    end
    @(negedge clk);
    #1;
    nchk++;
    if (grant !== '0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL release got grant=%b busy=%b exp 0000/0", grant, busy);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    req_valid = '1;
    ddr_valid = 1;
    cli_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    nchk++;
    if ({req_ready, req_done, grant, cli_valid, busy, gen_start, ddr_ready, gen_st_addr, gen_burst, gen_step, gen_burst_num} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs got rr=%b rd=%b g=%b cv=%b busy=%b gs=%b dr=%b exp all 0", req_ready, req_done,
               grant, cli_valid, busy, gen_start, ddr_ready);
    end
    req_valid = '0;
    ddr_valid = 0;
    cli_ready = '0;
    rst = 0;
  endtask
  task automatic test_single;
    run(2, 4'b0, 32'h1000, 8'd16, 32'h400, 8'd4, 1, 66, 0);
  endtask
  task automatic test_round_robin;
    int e;
    logic [3:0] oh;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++) begin
      req_st_addr[i*AW +: AW] = 32'h100 * (i + 1);
      req_burst[i*BW +: BW] = 8'd1;
      req_step[i*AW +: AW] = 32'd4;
      req_burst_num[i*BW +: BW] = 8'd1;
    end
    for (int k = 0; k < 5; k++) begin
`ifdef DDR_RD_ARB_PRIO_EN
      e = 0;
`else
      e = k % N;
`endif
      oh = 4'(1 << e);
      gen_q.push_back('{e, 32'h100 * (e + 1), 8'd1, 32'd4, 8'd1});
      done_q.push_back(e);
      @(negedge clk);
      if (k == 0) req_valid = '1;
      #1;
      nchk++;
      if (req_ready !== oh) begin nfail++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, oh); end
      @(negedge clk);
      @(negedge clk);
      ddr_valid = 1;
      cli_ready = '1;
      gen_done = 1;
      #1;
      nchk++;
      if (ddr_ready !== 1'b1 || cli_valid !== oh) begin
        nfail++;
        $display("FAIL rr_beat%0d got rdy=%b cv=%b exp rdy=1 cv=%b", k, ddr_ready, cli_valid, oh);
      end
      @(negedge clk);
      ddr_valid = 0;
      gen_done = 0;
      cli_ready = '0;
      if (k == 4) req_valid = '0;
      #1;
      nchk++;
      if (req_done !== oh || req_ready !== '0) begin
        nfail++;
        $display("FAIL rr_done%0d got done=%b ready=%b exp done=%b ready=0000", k, req_done, req_ready, oh);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_backpressure;
    run(1, 4'b0, 32'h8000, 8'd4, 32'h40, 8'd2, 1, 3, 1);
  endtask
  task automatic test_done_order;
    run(3, 4'b0, 32'hA000, 8'd2, 32'h10, 8'd2, 1, 7, 0);
    run(3, 4'b0, 32'hB000, 8'd2, 32'h10, 8'd2, 12, 5, 0);
    run(3, 4'b0, 32'hC000, 8'd2, 32'h10, 8'd2, 1, 4, 0);
  endtask
  task automatic test_zero_len;
    run(1, 4'b0, 32'hD000, 8'd8, 32'h20, 8'd0, 1, 1, 0);
    run(2, 4'b0, 32'hE000, 8'd0, 32'h20, 8'd5, 1, 1, 0);
  endtask
  task automatic test_reset_mid;
    gen_q.push_back('{1, 32'h2000, 8'd8, 32'h100, 8'd4});
    @(negedge clk);
    req_st_addr[1*AW +: AW] = 32'h2000;
    req_burst[1*BW +: BW] = 8'd8;
    req_step[1*AW +: AW] = 32'h100;
    req_burst_num[1*BW +: BW] = 8'd4;
    req_valid = 4'b0010;
    #1;
    nchk++;
    if (req_ready !== 4'b0010) begin nfail++; $display("FAIL mid_accept got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ddr_valid = 1;
      cli_ready = '1;
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    nchk++;
    if ({grant, busy, ddr_ready, cli_valid, req_done, gen_st_addr, gen_burst} !== '0) begin
      nfail++;
      $display("FAIL mid_reset got g=%b busy=%b dr=%b cv=%b rd=%b addr=%h exp all 0", grant, busy, ddr_ready,
               cli_valid, req_done, gen_st_addr);
    end
    rst = 0;
    ddr_valid = 0;
    cli_ready = '0;
    run(0, 4'b1000, 32'h3000, 8'd4, 32'h80, 8'd2, 1, 8, 0);
  endtask
  initial begin
    req_valid = '0;
    cli_ready = '0;
    req_st_addr = '0;
    req_burst = '0;
    req_step = '0;
    req_burst_num = '0;
    gen_done = 0;
    ddr_valid = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_done_order();
    test_zero_len();
    test_reset_mid();
    repeat (3) @(negedge clk);
    nchk++;
    if (gen_q.size() != 0 || done_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain got gen=%0d done=%0d exp 0/0", gen_q.size(), done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
